// File: rtl/svo_tpattern.sv
// svo_tpattern -- AXI-Stream test pattern generator.
//
// Produces one frame of SVO_HOR_PIXELS x SVO_VER_PIXELS pixels after another.
// The pattern is chosen by 'mode', which is sampled when pixel (0,0) is
// generated and then held for the rest of the frame:
//   0 grid, 1 colour bars, 2 checker, 3 horizontal gradient,
//   4 noise (only with SVO_TPATTERN_NOISE_EN defined), 5..7 black.
// Pixel word is {B,G,R}, red in the LSBs.
//
// Optional feature macro: SVO_TPATTERN_NOISE_EN adds a 32-bit Galois LFSR
// that drives mode 4. Without it mode 4 outputs black.
//
// Ports:
//   clk_pixel        pixel clock, all logic on its rising edge
//   reset            synchronous, active-high
//   mode[2:0]        pattern select, sampled at the start of each frame
//   out_axis_tvalid  pixel valid
//   out_axis_tready  sink accepts the pixel
//   out_axis_tdata   pixel data {B,G,R}
//   out_axis_tuser   start of frame, pixel (0,0)
//   out_axis_tlast   last pixel of a line
module svo_tpattern #(
   parameter int SVO_HOR_PIXELS     = 640,
   parameter int SVO_VER_PIXELS     = 480,
   parameter int SVO_BITS_PER_RED   = 8,
   parameter int SVO_BITS_PER_GREEN = 8,
   parameter int SVO_BITS_PER_BLUE  = 8,
   parameter int TILE_LOG2          = 5,
   localparam int BPP = SVO_BITS_PER_RED + SVO_BITS_PER_GREEN + SVO_BITS_PER_BLUE
) (
   input  logic           clk_pixel,
   input  logic           reset,
   input  logic [2:0]     mode,
   output logic           out_axis_tvalid,
   input  logic           out_axis_tready,
   output logic [BPP-1:0] out_axis_tdata,
   output logic           out_axis_tuser,
   output logic           out_axis_tlast
);

   localparam int RW  = SVO_BITS_PER_RED;
   localparam int GW  = SVO_BITS_PER_GREEN;
   localparam int BW  = SVO_BITS_PER_BLUE;
   localparam int HW  = (SVO_HOR_PIXELS > 1) ? $clog2(SVO_HOR_PIXELS) : 1;
   localparam int VW  = (SVO_VER_PIXELS > 1) ? $clog2(SVO_VER_PIXELS) : 1;
   localparam int T   = 1 << TILE_LOG2;
   // Offsets centre the tile grid within the active area.
   localparam logic [TILE_LOG2-1:0] HOFF = TILE_LOG2'(((T - (SVO_HOR_PIXELS % T)) % T) / 2);
   localparam logic [TILE_LOG2-1:0] VOFF = TILE_LOG2'(((T - (SVO_VER_PIXELS % T)) % T) / 2);

   logic [HW-1:0]        hcursor;
   logic [VW-1:0]        vcursor;
   logic [TILE_LOG2-1:0] xoff, yoff;
   logic [HW:0]          tx;
   logic [VW:0]          ty;
   logic [2:0]           mode_q;

   logic                 advance;
   logic                 sof, eol;
   logic [2:0]           cur_mode;
   logic [2:0]           bar;
   logic [RW-1:0]        pix_r;
   logic [GW-1:0]        pix_g;
   logic [BW-1:0]        pix_b;
   logic [BPP-1:0]       pixel;

`ifdef SVO_TPATTERN_NOISE_EN
   localparam logic [31:0] LFSR_TAPS = 32'h80200003;
   logic [31:0] lfsr;

   // Low BPP bits of the LFSR, repeated when the pixel is wider than 32 bits.
   function automatic logic [BPP-1:0] noise_bits(input logic [31:0] s);
      for (int unsigned i = 0; i < BPP; i++)
         noise_bits[i] = s[i % 32];
   endfunction
`endif

   assign advance = !out_axis_tvalid || out_axis_tready;

   always_comb begin
      sof      = (hcursor == '0) && (vcursor == '0);
      eol      = (hcursor == HW'(SVO_HOR_PIXELS - 1));
      // Pixel (0,0) already uses the freshly sampled mode.
      cur_mode = sof ? mode : mode_q;
      bar      = 3'((32'(hcursor) * 32'd8) / 32'(SVO_HOR_PIXELS));
      pix_r    = '0;
      pix_g    = '0;
      pix_b    = '0;
      pixel    = '0;
      case (cur_mode)
         3'd0: if (xoff == '0 || yoff == '0) pixel = '1;
         3'd1: begin
            // R on for bars {0,1,4,5}, G for {0..3}, B for even bars.
            pix_r = {RW{~bar[1]}};
            pix_g = {GW{~bar[2]}};
            pix_b = {BW{~bar[0]}};
            pixel = {pix_b, pix_g, pix_r};
         end
         3'd2: if (tx[0] ^ ty[0]) pixel = '1;
         3'd3: begin
            pix_r = RW'(hcursor);
            pix_g = GW'(hcursor);
            pix_b = BW'(hcursor);
            pixel = {pix_b, pix_g, pix_r};
         end
`ifdef SVO_TPATTERN_NOISE_EN
         3'd4: pixel = noise_bits(lfsr);
`endif
         default: pixel = '0;
      endcase
   end

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         out_axis_tvalid <= 1'b0;
         out_axis_tdata  <= '0;
         out_axis_tuser  <= 1'b0;
         out_axis_tlast  <= 1'b0;
         hcursor         <= '0;
         vcursor         <= '0;
         xoff            <= HOFF;
         yoff            <= VOFF;
         tx              <= '0;
         ty              <= '0;
         mode_q          <= '0;
`ifdef SVO_TPATTERN_NOISE_EN
         lfsr            <= 32'h00000001;
`endif
      end else if (advance) begin
         out_axis_tvalid <= 1'b1;
         out_axis_tdata  <= pixel;
         out_axis_tuser  <= sof;
         out_axis_tlast  <= eol;
         if (sof)
            mode_q <= mode;
`ifdef SVO_TPATTERN_NOISE_EN
         lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
`endif
         if (eol) begin
            hcursor <= '0;
            xoff    <= HOFF;
            tx      <= '0;
            if (vcursor == VW'(SVO_VER_PIXELS - 1)) begin
               vcursor <= '0;
               yoff    <= VOFF;
               ty      <= '0;
            end else begin
               vcursor <= vcursor + 1'b1;
               yoff    <= yoff + 1'b1;
               if (yoff == '1)
                  ty <= ty + 1'b1;
            end
         end else begin
            hcursor <= hcursor + 1'b1;
            xoff    <= xoff + 1'b1;
            if (xoff == '1)
               tx <= tx + 1'b1;
         end
      end
   end

endmodule
